// File: rtl/register_file.sv
// register_file: 32x64 register file, two combinational read ports, one clocked write port; define ZERO_REG_EN to make register 31 a hardwired zero
module register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  read_register_1,
  input  logic [4:0]  read_register_2,
  input  logic [4:0]  write_register,
  input  logic [63:0] write_data,
  input  logic        reg_write,
  output logic [63:0] read_data_1,
  output logic [63:0] read_data_2
);
  logic [63:0] regs [32];
  logic        write_en;
`ifdef ZERO_REG_EN
  assign write_en    = reg_write && (write_register != 5'd31);
  assign read_data_1 = (read_register_1 == 5'd31) ? '0 : regs[read_register_1];
  assign read_data_2 = (read_register_2 == 5'd31) ? '0 : regs[read_register_2];
`else
  assign write_en    = reg_write;
  assign read_data_1 = regs[read_register_1];
  assign read_data_2 = regs[read_register_2];
`endif
  // reset clears every register and overrides a same-edge write; an unknown enable takes the no-write branch
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_en) begin
      regs[write_register] <= write_data;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table vectors, corner sequences and randomized checks against an array model
module tb_register_file;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic        clk = 0;
  logic        reset = 0;
  logic [4:0]  read_register_1 = 0, read_register_2 = 0, write_register = 0;
  logic [63:0] write_data = 0;
  logic        reg_write = 0;
  logic [63:0] read_data_1, read_data_2;
  int vec = 0, miss = 0;
  logic [63:0] m [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1, ra2;
    logic [63:0] e1, e2;
  } vec_t;
  vec_t tbl [7];

  register_file dut (
    .clk(clk), .reset(reset),
    .read_register_1(read_register_1), .read_register_2(read_register_2),
    .write_register(write_register), .write_data(write_data), .reg_write(reg_write),
    .read_data_1(read_data_1), .read_data_2(read_data_2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mrd(input logic [4:0] a);
    return (ZR && a == 5'd31) ? 64'h0 : m[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // update the model from the inputs presented on this edge, then step past the edge
  task automatic tick();
    if (reset) for (int i = 0; i < 32; i++) m[i] = 64'h0;
    else if (reg_write && !(ZR && write_register == 5'd31)) m[write_register] = write_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a simultaneous write to reg 7: reset wins
    @(posedge clk); #1;
    reset = 1; reg_write = 1; write_register = 7; write_data = 64'h55;
    tick();
    reset = 0; reg_write = 0;
    for (int a = 0; a < 32; a++) begin
      read_register_1 = a[4:0]; read_register_2 = 5'(31 - a);
      #1;
      chk($sformatf("reset_rd1[%0d]", a), read_data_1, 64'h0);
      chk($sformatf("reset_rd2[%0d]", 31 - a), read_data_2, 64'h0);
    end

    tbl[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd5, 5'd5, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    tbl[1] = '{1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 5'd5, 64'h0, 64'hDEAD_BEEF_0123_4567};
    tbl[2] = '{1'b0, 5'd4,  64'h1,                   5'd4, 5'd6, 64'h0, 64'h0};
    tbl[3] = '{1'b1, 5'd9,  64'h1,                   5'd9, 5'd5, 64'h1, 64'hDEAD_BEEF_0123_4567};
    tbl[4] = '{1'b1, 5'd31, 64'h77,                  5'd31, 5'd0, ZR ? 64'h0 : 64'h77, 64'h0};
    tbl[5] = '{1'b1, 5'd0,  64'hA5A5_5A5A_0F0F_F0F0, 5'd0, 5'd31, 64'hA5A5_5A5A_0F0F_F0F0, ZR ? 64'h0 : 64'h77};
    tbl[6] = '{1'b1, 5'd7,  64'h11,                  5'd7, 5'd9, 64'h11, 64'h1};
    foreach (tbl[i]) begin
      reg_write = tbl[i].we; write_register = tbl[i].wa; write_data = tbl[i].wd;
      tick();
      reg_write = 0;
      read_register_1 = tbl[i].ra1; read_register_2 = tbl[i].ra2;
      #1;
      chk($sformatf("tbl%0d_rd1", i), read_data_1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), read_data_2, tbl[i].e2);
    end

    // same-edge read/write of reg 9: old value before the edge, new after
    read_register_1 = 9; reg_write = 1; write_register = 9; write_data = 64'h2;
    #1;
    chk("rw9_before", read_data_1, 64'h1);
    tick();
    chk("rw9_after", read_data_1, 64'h2);

    // inputs changed between edges with reg_write low must not write
    reg_write = 0; write_register = 9; write_data = 64'h3;
    #2 reg_write = 1;
    #1 reg_write = 0;
    tick();
    chk("between_edges", read_data_1, 64'h2);

    // reset mid-operation discards the write and clears reg 7
    read_register_2 = 7; reset = 1; reg_write = 1; write_register = 7; write_data = 64'h55;
    tick();
    chk("reset_prio_rd2", read_data_2, 64'h0);
    reset = 0;
    tick();
    chk("after_reset_write", read_data_2, 64'h55);

    // chain test
    reset = 1; reg_write = 0;
    tick();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      read_register_1 = i[4:0];
      #1;
      reg_write = 1; write_register = 5'(i + 1); write_data = read_data_1 + 64'h1;
      tick();
    end
    reg_write = 0;
    for (int k = 0; k < 32; k++) begin
      read_register_1 = k[4:0]; read_register_2 = k[4:0];
      #1;
      chk($sformatf("chain[%0d]", k), read_data_1,
          k == 0 ? (ZR ? 64'd1 : 64'd32) : (k == 31 && ZR) ? 64'd0 : 64'(k));
      chk($sformatf("chain_p2[%0d]", k), read_data_2, mrd(k[4:0]));
    end

    // randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      reg_write = $urandom_range(0, 3) != 0;
      write_register = 5'($urandom);
      write_data = {$urandom, $urandom};
      read_register_1 = 5'($urandom);
      read_register_2 = ($urandom_range(0, 3) == 0) ? write_register : 5'($urandom);
      #1;
      chk("rnd_pre_rd1", read_data_1, mrd(read_register_1));
      tick();
      chk("rnd_rd1", read_data_1, mrd(read_register_1));
      chk("rnd_rd2", read_data_2, mrd(read_register_2));
    end
    reset = 0; reg_write = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
